// File: rtl/cp0_unit.sv
// Coprocessor-0: STATUS/CAUSE/EPC/EHBR, MTC0/MFC0/ERET and one synchronised interrupt line.
// Latency: data_r, jump_en and jump_addr are combinational; register writes land at the next posedge.
// Backpressure: en=0 freezes the FSM, EPC and MTC0 writes; the synchroniser and IP2 latch keep running.
module cp0_unit #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EHBR_RST    = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        in_handler
);

  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_ERET  = 2'd2;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EHBR   = 5'd25;

  typedef enum logic {ST_IDLE, ST_HANDLER} state_t;

  state_t                 state_q, state_d;
  logic                   ie_q, ie_d;
  logic                   ip2_q, ip2_d;
  logic [31:0]            epc_q, epc_d;
  logic [31:0]            ehbr_q, ehbr_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_last_q, sync_last_d;

  logic do_eret;
  logic do_mtc0;
  logic accept;
  logic sync_edge;

  // Decode the issued operation and the interrupt-accept condition from pre-edge register values
  always_comb begin
    do_eret   = en & (oper == OP_ERET);
    do_mtc0   = en & (oper == OP_STORE);
    accept    = en & ie_q & ip2_q & (state_q == ST_IDLE) & (oper != OP_ERET);
    sync_edge = sync_q[SYNC_STAGES-1] & ~sync_last_q;
  end

  // Redirect request: ERET returns to EPC, an accepted interrupt enters the handler; muted in reset
  always_comb begin
    jump_en    = rst & (do_eret | accept);
    jump_addr  = do_eret ? epc_q : ehbr_q;
    in_handler = rst & (state_q == ST_HANDLER);
  end

  // MFC0 read mux; during reset it shows the values the registers are being reset to
  always_comb begin
    data_r = '0;
    case (addr_r)
      REG_STATUS: data_r = {31'b0, rst & ie_q};
      REG_CAUSE:  data_r = {21'b0, rst & ip2_q, 10'b0};
      REG_EPC:    data_r = rst ? epc_q : 32'h0;
      REG_EHBR:   data_r = rst ? ehbr_q : EHBR_RST;
      default:    data_r = '0;
    endcase
  end

  // Next-state logic; later assignments override earlier ones to encode same-cycle priority
  always_comb begin
    state_d     = state_q;
    ie_d        = ie_q;
    ip2_d       = ip2_q;
    epc_d       = epc_q;
    ehbr_d      = ehbr_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], ir_in};
    sync_last_d = sync_q[SYNC_STAGES-1];

    if (do_mtc0) begin
      case (addr_w)
        REG_STATUS: ie_d   = data_w[0];
        REG_CAUSE:  ip2_d  = data_w[10];
        REG_EPC:    epc_d  = data_w;
        REG_EHBR:   ehbr_d = data_w;
        default:    ;
      endcase
    end

    // Accept: the saved return PC beats an MTC0 to EPC in the same cycle
    if (accept) begin
      state_d = ST_HANDLER;
      epc_d   = ret_addr;
      ip2_d   = 1'b0;
    end else if (do_eret) begin
      state_d = ST_IDLE;
    end

    // A fresh synchronised edge always leaves IP2 pending, even against a clear
    if (sync_edge) begin
      ip2_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ie_q        <= 1'b0;
      ip2_q       <= 1'b0;
      epc_q       <= 32'h0;
      ehbr_q      <= EHBR_RST;
      sync_q      <= '0;
      sync_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ie_q        <= ie_d;
      ip2_q       <= ip2_d;
      epc_q       <= epc_d;
      ehbr_q      <= ehbr_d;
      sync_q      <= sync_d;
      sync_last_q <= sync_last_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, interrupt entry/return, IE gating, en stall, priority, mid-handler reset.
// Inputs change 1ns after each posedge; outputs are sampled later in the same cycle.
// Expected values are hand-computed constants for each step.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  oper;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [31:0] ret_addr;
  logic        ir_in;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        in_handler;

  int checks = 0;
  int errors = 0;

  cp0_unit #(.SYNC_STAGES(2), .EHBR_RST(32'h0000_0010)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .oper       (oper),
    .addr_r     (addr_r),
    .data_r     (data_r),
    .addr_w     (addr_w),
    .data_w     (data_w),
    .ret_addr   (ret_addr),
    .ir_in      (ir_in),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .in_handler (in_handler)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr_r = a;
    #1;
    chk(tag, data_r, exp);
  endtask

  task automatic jchk(input string tag, input logic exp_en, input logic [31:0] exp_addr);
    #1;
    chk({tag, "_en"}, {31'b0, jump_en}, {31'b0, exp_en});
    if (exp_en) chk({tag, "_addr"}, jump_addr, exp_addr);
  endtask

  task automatic hchk(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, in_handler}, {31'b0, exp});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; oper = 2'd1; addr_w = a; data_w = d;
    tick();
    oper = 2'd0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; oper = 2'd0; addr_r = 5'd0; addr_w = 5'd0;
    data_w = 32'h0; ret_addr = 32'h0; ir_in = 1'b0;

    // 1: reset, with an ERET presented to prove jump_en is muted
    tick();
    en = 1'b1; oper = 2'd2;
    jchk("rst_mute", 1'b0, 32'h0);
    tick();
    en = 1'b0; oper = 2'd0; rst = 1'b1;
    rd("rst_ehbr", 5'd25, 32'h10);
    rd("rst_status", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("unimpl_reg", 5'd5, 32'h0);
    jchk("rst_jump", 1'b0, 32'h0);
    hchk("rst_inh", 1'b0);

    // 2: IE=1, pulse ir_in, take the interrupt SYNC_STAGES+1 posedges later
    mtc0(5'd12, 32'h1);
    rd("ie_set", 5'd12, 32'h1);
    ret_addr = 32'h40; ir_in = 1'b1;
    jchk("t2_c0", 1'b0, 32'h0);
    tick(); jchk("t2_c1", 1'b0, 32'h0);
    tick(); jchk("t2_c2", 1'b0, 32'h0);
    tick(); jchk("t2_take", 1'b1, 32'h10);
    rd("t2_cause", 5'd13, 32'h400);
    ir_in = 1'b0;
    tick();
    rd("t2_epc", 5'd14, 32'h40);
    rd("t2_cause_clr", 5'd13, 32'h0);
    hchk("t2_inh", 1'b1);
    jchk("t2_after", 1'b0, 32'h0);

    // 3: ERET from the handler
    oper = 2'd2;
    jchk("t3_eret", 1'b1, 32'h40);
    tick();
    oper = 2'd0;
    hchk("t3_inh", 1'b0);
    jchk("t3_after", 1'b0, 32'h0);

    // 4: IE=0 keeps the request pending; enabling it takes it one cycle later
    mtc0(5'd12, 32'h0);
    ir_in = 1'b1;
    tick(); tick(); tick();
    ir_in = 1'b0;
    rd("t4_cause", 5'd13, 32'h400);
    jchk("t4_nojump", 1'b0, 32'h0);
    tick();
    jchk("t4_still", 1'b0, 32'h0);
    oper = 2'd1; addr_w = 5'd12; data_w = 32'h1; ret_addr = 32'h80;
    rd("t4_old_ie", 5'd12, 32'h0);
    jchk("t4_wrcyc", 1'b0, 32'h0);
    tick();
    oper = 2'd0;
    rd("t4_new_ie", 5'd12, 32'h1);
    jchk("t4_take", 1'b1, 32'h10);
    tick();
    rd("t4_epc", 5'd14, 32'h80);
    oper = 2'd2;
    jchk("t4_eret", 1'b1, 32'h80);
    tick();
    oper = 2'd0;

    // 5: en=0 stalls accept while IP2 still latches; raising en accepts at once
    en = 1'b0; ir_in = 1'b1;
    tick(); tick(); tick();
    ir_in = 1'b0;
    rd("t5_cause", 5'd13, 32'h400);
    jchk("t5_stall", 1'b0, 32'h0);
    tick();
    jchk("t5_stall2", 1'b0, 32'h0);
    hchk("t5_inh", 1'b0);
    en = 1'b1; ret_addr = 32'hC0;
    jchk("t5_take", 1'b1, 32'h10);
    tick();
    hchk("t5_inh2", 1'b1);
    rd("t5_epc", 5'd14, 32'hC0);
    en = 1'b0; oper = 2'd2;
    jchk("t5_eret_frz", 1'b0, 32'h0);
    tick();
    hchk("t5_frz_inh", 1'b1);
    en = 1'b1;
    jchk("t5_eret", 1'b1, 32'hC0);
    tick();
    oper = 2'd0;
    hchk("t5_idle", 1'b0);

    // 6: ERET in IDLE beats pending IP2; interrupt taken one cycle later
    en = 1'b0; ir_in = 1'b1;
    tick(); tick(); tick();
    ir_in = 1'b0;
    en = 1'b1; oper = 2'd2;
    jchk("t6_eret", 1'b1, 32'hC0);
    tick();
    oper = 2'd0; ret_addr = 32'h100;
    hchk("t6_idle", 1'b0);
    jchk("t6_take", 1'b1, 32'h10);
    tick();
    hchk("t6_inh", 1'b1);
    rd("t6_epc", 5'd14, 32'h100);
    // new edge inside the handler: pending but not nested
    ir_in = 1'b1;
    tick(); tick(); tick();
    ir_in = 1'b0;
    rd("t6_nest_ip2", 5'd13, 32'h400);
    jchk("t6_nonest", 1'b0, 32'h0);
    // mid-handler reset
    rst = 1'b0;
    hchk("t6_rst_inh", 1'b0);
    jchk("t6_rst_jump", 1'b0, 32'h0);
    rd("t6_rst_cause", 5'd13, 32'h0);
    tick();
    rst = 1'b1;
    hchk("t6_post_inh", 1'b0);
    rd("t6_post_cause", 5'd13, 32'h0);
    rd("t6_post_epc", 5'd14, 32'h0);
    rd("t6_post_ie", 5'd12, 32'h0);

    // EHBR rewrite, then accept together with an MTC0 to EPC: ret_addr wins
    oper = 2'd1; addr_w = 5'd25; data_w = 32'h200;
    rd("ehbr_old", 5'd25, 32'h10);
    tick();
    oper = 2'd0;
    rd("ehbr_new", 5'd25, 32'h200);
    mtc0(5'd12, 32'h1);
    ir_in = 1'b1;
    tick(); tick(); tick();
    ir_in = 1'b0;
    oper = 2'd1; addr_w = 5'd14; data_w = 32'hDEAD; ret_addr = 32'h300;
    jchk("pri_take", 1'b1, 32'h200);
    tick();
    oper = 2'd0;
    rd("pri_epc", 5'd14, 32'h300);
    hchk("pri_inh", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
